// File: rtl/host_pad_responder_if.sv
// Host command/trigger pins and internal memory bus of host_pad_responder.
// slave is the responder's view; master is the host/memory side.
interface host_pad_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              chip_en;
  logic              data_addr_valid;
  logic              read_write;
  logic [ADDR_W-1:0] address_in;
  logic [DATA_W-1:0] data_in;
  logic              trigger;
  logic              scan_start_exec;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              exec_end;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              exec_start;
  logic              exec_done;

  modport slave (
    input  chip_en, data_addr_valid, read_write, address_in, data_in,
           trigger, scan_start_exec, mem_gnt, mem_rvalid, mem_rdata, exec_done,
    output data_out, data_out_valid, exec_end, mem_req, mem_we, mem_addr,
           mem_wdata, exec_start
  );

  modport master (
    output chip_en, data_addr_valid, read_write, address_in, data_in,
           trigger, scan_start_exec, mem_gnt, mem_rvalid, mem_rdata, exec_done,
    input  data_out, data_out_valid, exec_end, mem_req, mem_we, mem_addr,
           mem_wdata, exec_start
  );
endinterface

// File: rtl/host_pad_responder.sv
// Turns host command/trigger edges into internal memory accesses or an execution run.
// Read response 2 cycles after grant at best; RD_TIMEOUT wait cycles before an all-ones error reply.
module host_pad_responder #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  host_pad_responder_if.slave bus
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_RD_REQ,
    S_RD_WAIT,
    S_RD_RESP,
    S_EXEC
  } state_e;

  state_e            state_q, state_d;
  logic              dav_q, trig_q, armed_q;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              exec_end_q, exec_end_d;
  logic              exec_start_q, exec_start_d;
  logic              dav_rise, trig_rise, in_req;

  // armed_q masks the first cycle after reset so a level already high is not an edge
  assign dav_rise  = armed_q & bus.data_addr_valid & ~dav_q;
  assign trig_rise = armed_q & bus.trigger & ~trig_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      dav_q        <= 1'b0;
      trig_q       <= 1'b0;
      armed_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      exec_end_q   <= 1'b0;
      exec_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dav_q        <= bus.data_addr_valid;
      trig_q       <= bus.trigger;
      armed_q      <= 1'b1;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      exec_end_q   <= exec_end_d;
      exec_start_q <= exec_start_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    exec_end_d   = exec_end_q;
    exec_start_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // a command edge wins over a simultaneous trigger edge
        if (bus.chip_en && dav_rise) begin
          addr_d  = bus.address_in;
          wdata_d = bus.data_in;
          we_d    = bus.read_write;
          state_d = bus.read_write ? S_WR_REQ : S_RD_REQ;
        end else if (bus.chip_en && trig_rise && bus.scan_start_exec) begin
          exec_end_d   = 1'b0;
          exec_start_d = 1'b1;
          state_d      = S_EXEC;
        end
      end
      S_WR_REQ: begin
        if (bus.mem_gnt) state_d = S_IDLE;
      end
      S_RD_REQ: begin
        if (bus.mem_gnt) begin
          cnt_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (bus.mem_rvalid) begin
          dout_d  = bus.mem_rdata;
          state_d = S_RD_RESP;
        end else if (cnt_q == TO_LAST) begin
          dout_d  = '1;
          state_d = S_RD_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RD_RESP: begin
        state_d = S_IDLE;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          exec_end_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign in_req             = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign bus.mem_req        = in_req;
  assign bus.mem_we         = in_req & we_q;
  assign bus.mem_addr       = in_req ? addr_q : '0;
  assign bus.mem_wdata      = in_req ? wdata_q : '0;
  assign bus.data_out       = dout_q;
  assign bus.data_out_valid = (state_q == S_RD_RESP);
  assign bus.exec_end       = exec_end_q;
  assign bus.exec_start     = exec_start_q;

endmodule

// File: tb/tb_host_pad_responder.sv
// Directed bench for host_pad_responder: transaction-level reference checked every cycle,
// plus literal expectations for the write, read, timeout, execution, conflict and reset cases.
module tb_host_pad_responder;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int TO = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  host_pad_responder_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  host_pad_responder #(.DATA_W(DW), .ADDR_W(AW), .RD_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: what the host should observe, by activity phase
  localparam int P_IDLE = 0, P_ACCESS = 1, P_WAIT = 2, P_RESP = 3, P_EXEC = 4;
  int          ph = P_IDLE;
  int          left = 0;
  logic        m_prev_dav = 1'b0, m_prev_trig = 1'b0, m_fresh = 1'b1;
  logic        cmd_edge, trig_edge;
  logic        m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] e_dout = '0;
  logic        e_dov = 1'b0, e_end = 1'b0, e_start = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = P_IDLE; left = 0;
      m_prev_dav = 1'b0; m_prev_trig = 1'b0; m_fresh = 1'b1;
      m_we = 1'b0; m_addr = '0; m_wdata = '0;
      e_dout = '0; e_dov = 1'b0; e_end = 1'b0; e_start = 1'b0;
    end else begin
      cmd_edge  = bus.data_addr_valid && !m_prev_dav && !m_fresh;
      trig_edge = bus.trigger && !m_prev_trig && !m_fresh;
      m_prev_dav  = bus.data_addr_valid;
      m_prev_trig = bus.trigger;
      m_fresh     = 1'b0;
      e_start = 1'b0;
      e_dov   = 1'b0;
      if (ph == P_IDLE) begin
        if (bus.chip_en && cmd_edge) begin
          m_we = bus.read_write; m_addr = bus.address_in; m_wdata = bus.data_in;
          ph = P_ACCESS;
        end else if (bus.chip_en && trig_edge && bus.scan_start_exec) begin
          e_end = 1'b0; e_start = 1'b1; ph = P_EXEC;
        end
      end else if (ph == P_ACCESS) begin
        if (bus.mem_gnt) begin
          ph = m_we ? P_IDLE : P_WAIT;
          left = TO;
        end
      end else if (ph == P_WAIT) begin
        left--;
        if (bus.mem_rvalid) begin
          e_dout = bus.mem_rdata; e_dov = 1'b1; ph = P_RESP;
        end else if (left == 0) begin
          e_dout = '1; e_dov = 1'b1; ph = P_RESP;
        end
      end else if (ph == P_RESP) begin
        ph = P_IDLE;
      end else if (ph == P_EXEC) begin
        if (bus.exec_done) begin
          e_end = 1'b1; ph = P_IDLE;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("data_out", 64'(bus.data_out), 64'(e_dout));
    chk("data_out_valid", 64'(bus.data_out_valid), 64'(e_dov));
    chk("exec_end", 64'(bus.exec_end), 64'(e_end));
    chk("exec_start", 64'(bus.exec_start), 64'(e_start));
    chk("mem_req", 64'(bus.mem_req), 64'(ph == P_ACCESS));
    if (ph == P_ACCESS) begin
      chk("mem_we", 64'(bus.mem_we), 64'(m_we));
      chk("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
    end else if (rst) begin
      chk("rst mem_we", 64'(bus.mem_we), 64'(0));
      chk("rst mem_addr", 64'(bus.mem_addr), 64'(0));
      chk("rst mem_wdata", 64'(bus.mem_wdata), 64'(0));
    end
  end

  // Event log used by the literal expectations
  int cyc = 0, n_dov = 0, n_wr = 0, n_req = 0, n_start = 0, g_cyc = 0, v_cyc = 0;
  logic [DW-1:0] v_dat = '0, wr_dat = '0;
  logic [AW-1:0] wr_addr = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.mem_req) n_req++;
    if (bus.mem_req && bus.mem_gnt) begin
      g_cyc = cyc;
      if (bus.mem_we) begin
        n_wr++; wr_addr = bus.mem_addr; wr_dat = bus.mem_wdata;
      end
    end
    if (bus.data_out_valid) begin
      n_dov++; v_cyc = cyc; v_dat = bus.data_out;
    end
    if (bus.exec_start) n_start++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  int r0, d0;

  initial begin
    bus.chip_en = 1'b1; bus.data_addr_valid = 1'b0; bus.read_write = 1'b0;
    bus.address_in = '0; bus.data_in = '0; bus.trigger = 1'b0; bus.scan_start_exec = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0; bus.exec_done = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(2);

    // write, grant after three waiting cycles
    bus.read_write = 1'b1; bus.address_in = 16'h0010; bus.data_in = 32'hA5A5_0001;
    bus.data_addr_valid = 1'b1;
    step(1);
    step(3);
    bus.mem_gnt = 1'b1;
    step(1);
    bus.mem_gnt = 1'b0; bus.data_addr_valid = 1'b0;
    step(3);
    chk("wr beats", 64'(n_wr), 64'(1));
    chk("wr addr", 64'(wr_addr), 64'(16'h0010));
    chk("wr data", 64'(wr_dat), 64'(32'hA5A5_0001));
    chk("wr req cycles", 64'(n_req), 64'(4));
    chk("wr no response", 64'(n_dov), 64'(0));

    // read, immediate grant, data one cycle later
    bus.read_write = 1'b0; bus.address_in = 16'h0020; bus.data_addr_valid = 1'b1;
    bus.mem_gnt = 1'b1;
    step(2);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    step(1);
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    step(3);
    chk("rd pulses", 64'(n_dov), 64'(1));
    chk("rd data", 64'(v_dat), 64'(32'h1234_5678));
    chk("rd latency", 64'(v_cyc - g_cyc), 64'(2));
    chk("rd data held", 64'(bus.data_out), 64'(32'h1234_5678));
    bus.data_addr_valid = 1'b0;
    step(1);

    // read that never returns data
    bus.address_in = 16'h0030; bus.data_addr_valid = 1'b1; bus.mem_gnt = 1'b1;
    step(2);
    bus.mem_gnt = 1'b0;
    step(TO + 3);
    chk("to pulses", 64'(n_dov), 64'(2));
    chk("to data", 64'(v_dat), 64'(32'hFFFF_FFFF));
    chk("to latency", 64'(v_cyc - g_cyc), 64'(TO + 1));
    chk("to back idle", 64'(bus.mem_req), 64'(0));
    bus.data_addr_valid = 1'b0;
    step(1);

    // trigger without start qualifier, stray exec_done
    bus.scan_start_exec = 1'b0; bus.trigger = 1'b1;
    step(3);
    chk("noscan no start", 64'(n_start), 64'(0));
    bus.trigger = 1'b0;
    step(1);
    bus.exec_done = 1'b1;
    step(1);
    bus.exec_done = 1'b0;
    step(1);
    chk("stray done", 64'(bus.exec_end), 64'(0));

    // execution run of 100 cycles, then a second start clears exec_end
    bus.scan_start_exec = 1'b1; bus.trigger = 1'b1;
    step(1);
    step(99);
    bus.exec_done = 1'b1;
    step(1);
    bus.exec_done = 1'b0;
    step(3);
    chk("one start", 64'(n_start), 64'(1));
    chk("exec_end held", 64'(bus.exec_end), 64'(1));
    bus.trigger = 1'b0;
    step(1);
    bus.trigger = 1'b1;
    step(2);
    chk("exec_end cleared", 64'(bus.exec_end), 64'(0));
    chk("two starts", 64'(n_start), 64'(2));
    bus.exec_done = 1'b1;
    step(1);
    bus.exec_done = 1'b0; bus.trigger = 1'b0;
    step(1);

    // command and trigger edges together: command wins
    bus.read_write = 1'b0; bus.address_in = 16'h0040; bus.data_addr_valid = 1'b1;
    bus.trigger = 1'b1; bus.mem_gnt = 1'b1;
    step(2);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_0040;
    step(1);
    bus.mem_rvalid = 1'b0;
    step(3);
    chk("conflict no start", 64'(n_start), 64'(2));
    chk("conflict pulses", 64'(n_dov), 64'(3));
    chk("conflict data", 64'(v_dat), 64'(32'hCAFE_0040));
    bus.data_addr_valid = 1'b0; bus.trigger = 1'b0;
    step(1);

    // command during execution is dropped
    bus.trigger = 1'b1;
    step(2);
    r0 = n_req;
    bus.read_write = 1'b1; bus.address_in = 16'h0050; bus.data_in = 32'h0000_0005;
    bus.data_addr_valid = 1'b1;
    step(5);
    bus.exec_done = 1'b1;
    step(1);
    bus.exec_done = 1'b0;
    step(3);
    chk("exec cmd no req", 64'(n_req - r0), 64'(0));
    chk("exec cmd run end", 64'(bus.exec_end), 64'(1));
    chk("three starts", 64'(n_start), 64'(3));
    bus.data_addr_valid = 1'b0; bus.trigger = 1'b0;
    step(1);

    // chip disabled ignores a command
    bus.chip_en = 1'b0; bus.data_addr_valid = 1'b1;
    step(3);
    chk("chip_en low no req", 64'(n_req - r0), 64'(0));
    bus.data_addr_valid = 1'b0;
    step(1);
    bus.chip_en = 1'b1;

    // reset while waiting for read data
    bus.read_write = 1'b0; bus.address_in = 16'h0060; bus.data_addr_valid = 1'b1;
    bus.mem_gnt = 1'b1;
    step(2);
    bus.mem_gnt = 1'b0;
    step(3);
    rst = 1'b1;
    #1;
    chk("rst data_out", 64'(bus.data_out), 64'(0));
    chk("rst exec_end", 64'(bus.exec_end), 64'(0));
    chk("rst mem_req now", 64'(bus.mem_req), 64'(0));
    step(2);
    rst = 1'b0;
    r0 = n_req; d0 = n_dov;
    step(1);
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_DEAD;
    step(1);
    bus.mem_rvalid = 1'b0;
    step(5);
    chk("no late response", 64'(n_dov - d0), 64'(0));
    chk("held dav no restart", 64'(n_req - r0), 64'(0));
    bus.data_addr_valid = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
